// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types and helpers for the cache/physical-memory arbiter.
// Holds the FSM state encoding, the latched operation type, the
// requester identity used by the optional round-robin grant, and the
// line-alignment helper used when a request is granted.
package cache_mem_arbiter_pkg;

  // Default geometry: a 256-bit (32-byte) line on a 32-bit address bus.
  localparam int LINE_W_DEFAULT = 256;
  localparam int ADDR_W_DEFAULT = 32;

  // Widest address the alignment helper handles.
  localparam int ADDR_W_MAX = 64;

  // Arbiter FSM states. The BUSY and DONE states are split per requester so
  // the response pulse can be steered without extra registers.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    D_BUSY = 3'd1,
    I_BUSY = 3'd2,
    D_DONE = 3'd3,
    I_DONE = 3'd4
  } arb_state_t;

  // Direction of the line transaction latched at grant time.
  typedef enum logic {
    ARB_READ  = 1'b0,
    ARB_WRITE = 1'b1
  } arb_op_t;

  // Requester identity. The round-robin grant uses it to remember who was
  // served last.
  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } arb_req_t;

  // Clear the byte-offset bits of an address so it points at the start of a
  // line of line_w bits. The caller narrows the result to its own width.
  function automatic logic [ADDR_W_MAX-1:0] line_align(
    input logic [ADDR_W_MAX-1:0] addr,
    input int                    line_w
  );
    logic [ADDR_W_MAX-1:0] mask;
    mask = ~((ADDR_W_MAX'(1) << $clog2(line_w / 8)) - ADDR_W_MAX'(1));
    return addr & mask;
  endfunction

endpackage

// File: rtl/cache_mem_arbiter_line_reg.sv
// Line-wide load register with asynchronous active-low clear.
// Used for the latched write-back data and for the read line buffer.
module cache_mem_arbiter_line_reg #(
  parameter int W = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Hold the value until load is asserted; clear on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbiter sharing one physical-memory port between the I-cache (line
// fills) and the D-cache (line fills and write-backs).
//
// One line transaction is in flight at a time. A grant in IDLE latches the
// line-aligned address, the write-back data and the operation; the memory
// command is driven from those registers until pmem_resp, then the granted
// requester gets a one-cycle response pulse and the FSM returns to IDLE.
//
// Build option: define ARB_ROUND_ROBIN_EN to alternate grants when both
// caches request together. Without it the D-cache always wins.
module cache_mem_arbiter
  import cache_mem_arbiter_pkg::*;
#(
  parameter int LINE_W = LINE_W_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  // I-cache side
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  // D-cache side
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  // Physical-memory side
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  arb_state_t        state;
  arb_op_t           op;
  logic [ADDR_W-1:0] addr;
  logic [LINE_W-1:0] wdata;
  logic [LINE_W-1:0] line_buf;

  logic              req_d;
  logic              req_i;
  logic              grant_d;
  logic              grant_i;
  logic [ADDR_W-1:0] grant_addr;
  logic [ADDR_W-1:0] aligned_addr;
  logic              busy;
  logic              wdata_load;
  logic              line_load;

`ifdef ARB_ROUND_ROBIN_EN
  arb_req_t          last_grant;
`endif

  // A D-cache request is either kind of D access; a simultaneous read and
  // write is handled as a write further down.
  assign req_d = d_read | d_write;
  assign req_i = i_read;

  // Grant decision, only meaningful in IDLE; requests are ignored elsewhere.
  always_comb begin
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (state == IDLE) begin
`ifdef ARB_ROUND_ROBIN_EN
      if (req_d && req_i) begin
        grant_d = (last_grant == REQ_I);
        grant_i = (last_grant == REQ_D);
      end else begin
        grant_d = req_d;
        grant_i = req_i;
      end
`else
      grant_d = req_d;
      grant_i = req_i & ~req_d;
`endif
    end
  end

  // Address of the winning requester, aligned to the start of its line.
  assign grant_addr   = grant_d ? d_address : i_address;
  assign aligned_addr = ADDR_W'(line_align(ADDR_W_MAX'(grant_addr), LINE_W));

  assign busy       = (state == D_BUSY) || (state == I_BUSY);
  assign wdata_load = grant_d | grant_i;
  assign line_load  = busy && pmem_resp && (op == ARB_READ);

  cache_mem_arbiter_line_reg #(
    .W (LINE_W)
  ) u_wdata_reg (
    .clk  (clk),
    .rst  (rst),
    .load (wdata_load),
    .d    (d_wdata),
    .q    (wdata)
  );

  cache_mem_arbiter_line_reg #(
    .W (LINE_W)
  ) u_line_buf (
    .clk  (clk),
    .rst  (rst),
    .load (line_load),
    .d    (pmem_rdata),
    .q    (line_buf)
  );

  assign pmem_address = addr;
  assign pmem_wdata   = wdata;
  assign i_rdata      = line_buf;
  assign d_rdata      = line_buf;

  // Transaction FSM: grant, hold the memory command, then pulse the response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      op         <= ARB_READ;
      addr       <= '0;
      pmem_read  <= 1'b0;
      pmem_write <= 1'b0;
      i_resp     <= 1'b0;
      d_resp     <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant <= REQ_I;
`endif
    end else begin
      i_resp <= 1'b0;
      d_resp <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            state      <= D_BUSY;
            addr       <= aligned_addr;
            op         <= d_write ? ARB_WRITE : ARB_READ;
            pmem_read  <= ~d_write;
            pmem_write <= d_write;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant <= REQ_D;
`endif
          end else if (grant_i) begin
            state      <= I_BUSY;
            addr       <= aligned_addr;
            op         <= ARB_READ;
            pmem_read  <= 1'b1;
            pmem_write <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant <= REQ_I;
`endif
          end
        end
        D_BUSY: begin
          if (pmem_resp) begin
            state      <= D_DONE;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
            d_resp     <= 1'b1;
          end
        end
        I_BUSY: begin
          if (pmem_resp) begin
            state      <= I_DONE;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
            i_resp     <= 1'b1;
          end
        end
        D_DONE: begin
          state <= IDLE;
        end
        I_DONE: begin
          state <= IDLE;
        end
        default: begin
          state      <= IDLE;
          pmem_read  <= 1'b0;
          pmem_write <= 1'b0;
        end
      endcase
    end
  end

endmodule
